// File: rtl/stopwatch_pkg.sv
// Shared widths, limits and the time-triple type for the stopwatch.
package stopwatch_pkg;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } sw_time_t;

endpackage

// File: rtl/sw_mod_counter.sv
// Modulo-N counter with enable; o_carry flags the enabled cycle that wraps N-1 -> 0.
module sw_mod_counter #(
    parameter int W = 6,
    parameter int N = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_value,
    output logic         o_carry
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= (r_value == LAST) ? '0 : r_value + 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_en && (r_value == LAST);

endmodule

// File: rtl/stopwatch.sv
// Run/pause h:m:s stopwatch with an inline tick prescaler.
// Define STOPWATCH_OVF_EN to add a sticky ovf output set on the full wrap.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int HOUR_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour
`ifdef STOPWATCH_OVF_EN
    ,
    output logic              ovf
`endif
);

    logic     w_tick;
    logic     w_sec_carry;
    logic     w_min_carry;
    logic     w_hour_wrap;
    sw_time_t w_time;

    // The prescaler freezes with start_stop so partial seconds survive a pause.
    generate
        if (TICK_DIV == 1) begin : g_no_presc
            assign w_tick = start_stop;
        end else begin : g_presc
            localparam int            PW     = $clog2(TICK_DIV);
            localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

            logic [PW-1:0] r_presc;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_presc <= '0;
                end else if (start_stop) begin
                    r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
                end
            end

            assign w_tick = start_stop && (r_presc == P_LAST);
        end
    endgenerate

    sw_mod_counter #(.W(SEC_W), .N(SEC_MAX + 1)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_tick),
        .o_value (w_time.sec),
        .o_carry (w_sec_carry)
    );

    sw_mod_counter #(.W(MIN_W), .N(MIN_MAX + 1)) u_min (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_sec_carry),
        .o_value (w_time.min),
        .o_carry (w_min_carry)
    );

    sw_mod_counter #(.W(HOUR_W), .N(HOUR_MAX + 1)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_min_carry),
        .o_value (w_time.hour),
        .o_carry (w_hour_wrap)
    );

    assign sec  = w_time.sec;
    assign min  = w_time.min;
    assign hour = w_time.hour;

`ifdef STOPWATCH_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_hour_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_hour_wrap;
`endif

endmodule

// File: tb/tb_stopwatch.sv
// Bench for stopwatch: TICK_DIV=1 and TICK_DIV=4 instances driven side by side.
module tb_stopwatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss1;
    logic       ss4;
    logic [5:0] sec1, min1, sec4, min4;
    logic [3:0] hour1, hour4;
`ifdef STOPWATCH_OVF_EN
    logic       ovf1, ovf4;
`endif

    always #5 clk = ~clk;

    stopwatch #(.TICK_DIV(1), .HOUR_MAX(15)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start_stop (ss1),
        .sec        (sec1),
        .min        (min1),
        .hour       (hour1)
`ifdef STOPWATCH_OVF_EN
        ,
        .ovf        (ovf1)
`endif
    );

    stopwatch #(.TICK_DIV(4), .HOUR_MAX(15)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start_stop (ss4),
        .sec        (sec4),
        .min        (min4),
        .hour       (hour4)
`ifdef STOPWATCH_OVF_EN
        ,
        .ovf        (ovf4)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    // Reference model: total elapsed seconds plus a prescaler count per instance.
    int   m_secs[2];
    int   m_pre[2];
    logic m_ovf[2];
    int   div_tab[2] = '{1, 4};

    localparam int FULL_DAY = 16 * 3600;

    typedef struct {
        logic        rst_b;
        logic        s1;
        logic        s4;
        int          n;
        logic [15:0] e1;
        logic [15:0] e4;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] hms(int h, int m, int s);
        return {4'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] to_time(int s);
        return {4'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0d:%0d:%0d req=%0d:%0d:%0d @%0t", name,
                     act[15:12], act[11:6], act[5:0], req[15:12], req[11:6], req[5:0], $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%b req=%b @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_clock(input int d, input logic en);
        if (en) begin
            m_pre[d]++;
            if (m_pre[d] == div_tab[d]) begin
                m_pre[d] = 0;
                if (m_secs[d] == FULL_DAY - 1) begin
                    m_secs[d] = 0;
                    m_ovf[d]  = 1'b1;
                end else begin
                    m_secs[d]++;
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_secs[d] = 0;
            m_pre[d]  = 0;
            m_ovf[d]  = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic step(input logic s1, input logic s4);
        logic [31:0] e;
        ss1 = s1;
        ss4 = s4;
        @(posedge clk);
        model_clock(0, s1);
        model_clock(1, s4);
        exp_q.push_back({to_time(m_secs[0]), to_time(m_secs[1])});
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty act=0 req=1 @%0t", $time);
        end else begin
            e = exp_q.pop_front();
            check16("sb_t1", {hour1, min1, sec1}, e[31:16]);
            check16("sb_t4", {hour4, min4, sec4}, e[15:0]);
        end
`ifdef STOPWATCH_OVF_EN
        check1("sb_ovf1", ovf1, m_ovf[0]);
        check1("sb_ovf4", ovf4, m_ovf[1]);
`endif
    endtask

    task automatic do_reset();
        ss1 = 1'b0;
        ss4 = 1'b0;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check16("rst_t1", {hour1, min1, sec1}, 16'h0);
        check16("rst_t4", {hour4, min4, sec4}, 16'h0);
`ifdef STOPWATCH_OVF_EN
        check1("rst_ovf1", ovf1, 1'b0);
        check1("rst_ovf4", ovf4, 1'b0);
`endif
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ss1 = 1'b0;
        ss4 = 1'b0;
        model_clear();

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1,  hms(0, 0, 0), hms(0, 0, 0)};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 3,  hms(0, 0, 3), hms(0, 0, 0)};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 10, hms(0, 0, 3), hms(0, 0, 0)};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1,  hms(0, 0, 4), hms(0, 0, 1)};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1,  hms(0, 0, 5), hms(0, 0, 1)};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 25, hms(0, 0, 5), hms(0, 0, 1)};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 3,  hms(0, 0, 8), hms(0, 0, 1)};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8,  hms(0, 0, 8), hms(0, 0, 2)};

        #2;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_b) do_reset();
            repeat (vecs[v].n) step(vecs[v].s1, vecs[v].s4);
            check16("vec_t1", {hour1, min1, sec1}, vecs[v].e1);
            check16("vec_t4", {hour4, min4, sec4}, vecs[v].e4);
        end

        // Asynchronous reset mid-count, observed before the next clock edge.
        do_reset();
        repeat (7) step(1'b1, 1'b0);
        check16("pre_async_t1", {hour1, min1, sec1}, hms(0, 0, 7));
        rst = 1'b0;
        #2;
        check16("async_t1", {hour1, min1, sec1}, 16'h0);
        check16("async_t4", {hour4, min4, sec4}, 16'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0);
        check16("post_async_t1", {hour1, min1, sec1}, hms(0, 0, 1));

        // Carries through every field up to the full 15:59:59 -> 0:00:00 wrap.
        do_reset();
        for (int i = 1; i <= FULL_DAY; i++) begin
            step(1'b1, 1'b1);
            if (i == 58)   check16("c58",   {hour1, min1, sec1}, hms(0, 0, 58));
            if (i == 59)   check16("c59",   {hour1, min1, sec1}, hms(0, 0, 59));
            if (i == 60)   check16("c60",   {hour1, min1, sec1}, hms(0, 1, 0));
            if (i == 3599) check16("c3599", {hour1, min1, sec1}, hms(0, 59, 59));
            if (i == 3600) check16("c3600", {hour1, min1, sec1}, hms(1, 0, 0));
            if (i == FULL_DAY - 1) begin
                check16("c_last", {hour1, min1, sec1}, hms(15, 59, 59));
`ifdef STOPWATCH_OVF_EN
                check1("ovf_before_wrap", ovf1, 1'b0);
`endif
            end
            if (i == FULL_DAY) begin
                check16("c_wrap", {hour1, min1, sec1}, hms(0, 0, 0));
                check16("c_wrap_t4", {hour4, min4, sec4}, hms(4, 0, 0));
`ifdef STOPWATCH_OVF_EN
                check1("ovf_at_wrap", ovf1, 1'b1);
                check1("ovf4_no_wrap", ovf4, 1'b0);
`endif
            end
        end
        repeat (5) step(1'b1, 1'b0);
        check16("after_wrap_t1", {hour1, min1, sec1}, hms(0, 0, 5));
`ifdef STOPWATCH_OVF_EN
        check1("ovf_sticky", ovf1, 1'b1);
`endif
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
